// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, requester ids,
// the latched memory command and the alignment rule.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_L = 1'b1
  } req_id_e;

  // "byte" is a keyword, so the byte-access flag is called byte_op.
  typedef struct packed {
    logic        write;
    logic        rdu;
    logic        byte_op;
    logic        hwrd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Byte wins over hwrd when both are set; bytes can never be misaligned.
  function automatic logic is_misaligned(input mem_cmd_t cmd);
    logic mis;
    if (cmd.byte_op) begin
      mis = 1'b0;
    end else if (cmd.hwrd) begin
      mis = cmd.addr[0];
    end else begin
      mis = |cmd.addr[1:0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_arb_sel.sv
// Winner select between CPU (C) and loader (L) with a starvation counter that
// forces L after MAX_WAIT consecutive contested wins by C.
module dmem_arb_sel
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_c_req,
  input  logic    i_l_req,
  input  logic    i_take,
  output req_id_e o_winner
);

  logic [3:0] r_wait;

  always_comb begin
    o_winner = REQ_C;
    if (i_l_req && (!i_c_req || (r_wait >= 4'(MAX_WAIT)))) begin
      o_winner = REQ_L;
    end
  end

  // Only contested C wins count; any L win clears the history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait <= 4'd0;
    end else if (i_take && (i_c_req || i_l_req)) begin
      if (o_winner == REQ_L) begin
        r_wait <= 4'd0;
      end else if (i_l_req) begin
        r_wait <= r_wait + 4'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-requester arbiter for the single data-memory R/W port. One command in
// flight; reads keep the command on the port through the result cycle.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_c_req,
  input  logic        i_c_write,
  input  logic        i_c_byte,
  input  logic        i_c_hwrd,
  input  logic        i_c_rdu,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  output logic        o_c_gnt,
  output logic        o_c_err,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  input  logic        i_l_req,
  input  logic        i_l_write,
  input  logic        i_l_byte,
  input  logic        i_l_hwrd,
  input  logic        i_l_rdu,
  input  logic [31:0] i_l_addr,
  input  logic [31:0] i_l_wdata,
  output logic        o_l_gnt,
  output logic        o_l_err,
  output logic        o_l_rvalid,
  output logic [31:0] o_l_rdata,
  output logic        o_mem_write,
  output logic        o_mem_rdu,
  output logic        o_mem_byte,
  output logic        o_mem_hwrd,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_result
);

  arb_state_e r_state;
  mem_cmd_t   r_cmd;
  req_id_e    r_id;
  logic       r_mis;
  logic       r_drive;
  logic       r_mem_write;
  logic       r_c_gnt, r_l_gnt, r_c_err, r_l_err, r_c_rvalid, r_l_rvalid;

  mem_cmd_t   w_c_cmd, w_l_cmd, w_win_cmd;
  req_id_e    w_winner;
  logic       w_win_mis;
  logic       w_take;
  logic       w_live;

  assign w_c_cmd   = '{write: i_c_write, rdu: i_c_rdu, byte_op: i_c_byte,
                       hwrd: i_c_hwrd, addr: i_c_addr, wdata: i_c_wdata};
  assign w_l_cmd   = '{write: i_l_write, rdu: i_l_rdu, byte_op: i_l_byte,
                       hwrd: i_l_hwrd, addr: i_l_addr, wdata: i_l_wdata};
  assign w_win_cmd = (w_winner == REQ_L) ? w_l_cmd : w_c_cmd;
  assign w_win_mis = is_misaligned(w_win_cmd);
  assign w_take    = (r_state == IDLE);

  dmem_arb_sel #(
    .MAX_WAIT (MAX_WAIT)
  ) u_sel (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_c_req  (i_c_req),
    .i_l_req  (i_l_req),
    .i_take   (w_take),
    .o_winner (w_winner)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_id        <= REQ_C;
      r_mis       <= 1'b0;
      r_drive     <= 1'b0;
      r_mem_write <= 1'b0;
      r_c_gnt     <= 1'b0;
      r_l_gnt     <= 1'b0;
      r_c_err     <= 1'b0;
      r_l_err     <= 1'b0;
      r_c_rvalid  <= 1'b0;
      r_l_rvalid  <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_c_gnt     <= 1'b0;
      r_l_gnt     <= 1'b0;
      r_c_err     <= 1'b0;
      r_l_err     <= 1'b0;
      r_c_rvalid  <= 1'b0;
      r_l_rvalid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_c_req || i_l_req) begin
            r_cmd       <= w_win_cmd;
            r_id        <= w_winner;
            r_mis       <= w_win_mis;
            r_drive     <= 1'b1;
            r_mem_write <= w_win_cmd.write && !w_win_mis;
            r_c_gnt     <= (w_winner == REQ_C);
            r_l_gnt     <= (w_winner == REQ_L);
            r_c_err     <= (w_winner == REQ_C) && w_win_mis;
            r_l_err     <= (w_winner == REQ_L) && w_win_mis;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_mis || r_cmd.write) begin
            r_drive <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_c_rvalid <= (r_id == REQ_C);
            r_l_rvalid <= (r_id == REQ_L);
            r_state    <= HOLD;
          end
        end
        default: begin
          r_drive <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Gating by reset suppresses a write or rvalid in the very cycle reset arrives.
  assign w_live      = !i_rst;
  assign o_mem_write = w_live && r_mem_write;
  assign o_mem_rdu   = w_live && r_drive && r_cmd.rdu;
  assign o_mem_byte  = w_live && r_drive && r_cmd.byte_op;
  assign o_mem_hwrd  = w_live && r_drive && r_cmd.hwrd;
  assign o_mem_addr  = (w_live && r_drive) ? r_cmd.addr  : 32'd0;
  assign o_mem_wdata = (w_live && r_drive) ? r_cmd.wdata : 32'd0;

  assign o_c_gnt    = w_live && r_c_gnt;
  assign o_l_gnt    = w_live && r_l_gnt;
  assign o_c_err    = w_live && r_c_err;
  assign o_l_err    = w_live && r_l_err;
  assign o_c_rvalid = w_live && r_c_rvalid;
  assign o_l_rvalid = w_live && r_l_rvalid;
  assign o_c_rdata  = o_c_rvalid ? i_mem_result : 32'd0;
  assign o_l_rdata  = o_l_rvalid ? i_mem_result : 32'd0;

endmodule
